uart_tx_param: RTL and testbench
================================

Name: uart_tx_param

Overview:
- Parametrised UART serial transmitter; next generation of the lab byte transmitter.
- Adds configurable data width, an internal baud divider, 1 or 2 stop bits, a valid/ready input handshake, and busy/done status.
- Sits between a byte/word producer (e.g. a command FSM or FIFO) and the board TX pin.
- Sends LSB first in standard 8N1/8N2-style framing.

Parameters:
- DATA_BITS, 8, payload width per frame; legal range 5..9.
- CLKS_PER_BIT, 434, clk cycles per serial bit; legal values ≥2 (434 gives 115200 baud at 50 MHz).
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  DATA_BITS  payload to send.
- in_valid  input  1  producer has a payload on in_data.
- in_ready  output  1  transmitter can accept a payload this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame's last stop bit completes.
- parity_odd  input  1  parity select, 0 = even, 1 = odd. Present only with UART_TX_PARITY_EN.

Behaviour:
- Reset (sampled on clk rising edge)
  - State = IDLE; tx=1, in_ready=1, busy=0, done=0.
  - Baud counter, bit index and shift register cleared.
  - Reset mid-frame aborts the frame immediately: tx=1 on the next cycle, with no partial stop bit.
- Handshake
  - Transfer occurs on a rising edge where in_valid=1 and in_ready=1.
  - in_data is latched into the shift register at that edge; later changes on in_data do not affect the frame.
  - in_ready=1 only in IDLE (combinational from state). in_valid while not ready is ignored; the producer must hold it.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - IDLE: tx=1. On transfer, go to START; the baud counter loads 0.
  - START: tx=0 for exactly CLKS_PER_BIT cycles. tx falls on the first cycle after the transfer edge, so latency from transfer to tx low is 1 cycle.
  - DATA: DATA_BITS bits, each held CLKS_PER_BIT cycles, bit 0 first. Implement as a shift register or index counter; width is $clog2(DATA_BITS).
  - PARITY: only with the macro; one bit period.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. done=1 in the last cycle of STOP; IDLE follows on the next edge.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT cycles, where P = 1 with parity and 0 without.
- Back-to-back frames
  - in_ready rises the cycle after done.
  - A transfer in that first IDLE cycle starts the next START immediately, so the minimum gap between stop bit and next start bit is 1 clk.
- tx is registered (no glitches) and is the only output driven from sequential logic beyond status.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - parity_odd port exists.
  - A PARITY state is inserted after DATA.
  - Parity bit = XOR of the latched payload, XOR parity_odd; parity_odd is sampled at the transfer edge.
- When undefined:
  - No port, no PARITY state.
  - Frame is start + data + stop only.

Test Plan:
- Reset then idle, CLKS_PER_BIT=4, DATA_BITS=8: hold in_valid=0 for 50 cycles -> tx=1, in_ready=1, busy=0, done never asserted.
- Send 0xA5 (no parity, STOP_BITS=1) -> tx sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 4 cycles. Total 40 cycles. done pulses once, in cycle 40 after transfer.
- Back-to-back 0x00 then 0xFF with in_valid held high -> second start bit begins 1 cycle after first done; in_ready high for exactly 1 cycle between frames; second frame data bits all 1.
- Parity build, 0xA5: parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; frame 44 cycles at CLKS_PER_BIT=4. Also STOP_BITS=2 -> stop high for 8 cycles before done.
- Reset asserted at cycle 15 of a 0x3C frame -> next cycle tx=1, busy=0, in_ready=1, no done; a new 0x3C frame after reset is bit-exact.
- Change in_data and pulse in_valid during busy -> ignored; in-flight frame unchanged; no second frame starts.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input, LSB-first framing, 1 or 2 stop bits.
// Optional even/odd parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                 parity_odd
`endif
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE_LAST = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST      = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t                 state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   stop_idx;
  logic                   tx_q;
  logic                   done_q;
  logic                   bit_end;
  logic                   last_stop;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;

  // in_ready is decoded straight from state so a producer sees it in the first IDLE cycle.
  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign tx       = tx_q;
  assign done     = done_q;

  // NOTE: every register here is updated with <= so all next-state terms see
  // the pre-edge values of state, baud_cnt and shift_reg consistently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      stop_idx  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      // done is registered one cycle ahead so it lines up with the final stop-bit cycle.
      done_q <= (state == S_STOP) && last_stop && (baud_cnt == BAUD_PRE_LAST);

      if (state != S_IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
      end

      case (state)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (in_valid) begin
            shift_reg <= in_data;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^in_data) ^ parity_odd;
`endif
            baud_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            tx_q      <= 1'b0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            tx_q      <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= S_DATA;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= parity_q;
              state <= S_PARITY;
`else
              tx_q  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              tx_q      <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            tx_q  <= 1'b1;
            state <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          tx_q <= 1'b1;
          if (bit_end) begin
            if (last_stop) begin
              state <= S_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          tx_q  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param at CLKS_PER_BIT=4, DATA_BITS=8, with a 1-stop and a 2-stop instance.
// Expected tx levels come from a small framing model (start, LSB-first data, optional parity, stops).
module tb_uart_tx_param;

  localparam int CPB  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P_BITS = 1;
`else
  localparam int P_BITS = 0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_valid2;
  logic       parity_odd;
  logic       in_ready, tx, busy, done;
  logic       in_ready2, tx2, busy2, done2;

  int errors = 0;
  int checks = 0;

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
`ifdef UART_TX_PARITY_EN
    ,
    .parity_odd(parity_odd)
`endif
  );

  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .tx        (tx2),
    .busy      (busy2),
    .done      (done2)
`ifdef UART_TX_PARITY_EN
    ,
    .parity_odd(parity_odd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level expected on the line during bit period k of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input logic podd, input int k);
    logic par;
    par = (^d) ^ podd;
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && P_BITS == 1) return par;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) in_valid2 = v;
    else     in_valid  = v;
  endtask

  task automatic wait_ready(input bit sel);
    int i;
    i = 0;
    while (((sel ? in_ready2 : in_ready) !== 1'b1) && i < 200) begin
      step();
      i++;
    end
    checks++;
    if ((sel ? in_ready2 : in_ready) !== 1'b1) begin
      errors++;
      $display("FAIL wait_ready sel=%0d: in_ready=%b required 1 within 200 cycles", sel,
               sel ? in_ready2 : in_ready);
    end
  endtask

  // Presents d and leaves in_valid high; returns #1 after the transfer edge.
  task automatic start_tx(input bit sel, input logic [7:0] d, input logic podd);
    wait_ready(sel);
    in_data    = d;
    parity_odd = podd;
    set_valid(sel, 1'b1);
    step();
  endtask

  // Called #1 after the transfer edge; checks every cycle of the frame.
  task automatic run_frame(input bit sel, input logic [7:0] d, input logic podd,
                           input int stop_bits, input bit hold, input bit disturb,
                           input string name);
    int   n;
    logic [3:0] obs, expv;
    n = (1 + 8 + P_BITS + stop_bits) * CPB;
    for (int c = 0; c < n; c++) begin
      if (c == 0) begin
        in_data = ~d;
        set_valid(sel, hold);
      end
      if (disturb && c == 10) begin
        in_data = 8'h00;
        set_valid(sel, 1'b1);
      end
      if (disturb && c == 11) set_valid(sel, 1'b0);
      obs  = sel ? {tx2, busy2, in_ready2, done2} : {tx, busy, in_ready, done};
      expv = {exp_bit(d, podd, c / CPB), 1'b1, 1'b0, (c == n - 1)};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s cycle %0d: tx/busy/ready/done=%b required %b", name, c + 1, obs, expv);
      end
      step();
    end
  endtask

  task automatic check_idle(input bit sel, input string name);
    logic [3:0] obs;
    obs = sel ? {tx2, in_ready2, busy2, done2} : {tx, in_ready, busy, done};
    checks++;
    if (obs !== 4'b1100) begin
      errors++;
      $display("FAIL %s: tx/ready/busy/done=%b required 1100", name, obs);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_idle(1'b0, "reset_dut1");
    check_idle(1'b1, "reset_dut2");
    for (int i = 0; i < 50; i++) begin
      step();
      check_idle(1'b0, "idle_hold");
    end
  endtask

  task automatic test_single_frame();
    start_tx(1'b0, 8'hA5, 1'b0);
    run_frame(1'b0, 8'hA5, 1'b0, 1, 1'b0, 1'b0, "frame_a5");
    check_idle(1'b0, "after_a5");
  endtask

  task automatic test_back_to_back();
    start_tx(1'b0, 8'h00, 1'b0);
    // in_valid stays high; run_frame switches in_data to 0xFF after the transfer.
    run_frame(1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b0, "b2b_first");
    checks++;
    if ({in_ready, tx} !== 2'b11) begin
      errors++;
      $display("FAIL b2b_gap: ready/tx=%b required 11", {in_ready, tx});
    end
    step();
    run_frame(1'b0, 8'hFF, 1'b0, 1, 1'b0, 1'b0, "b2b_second");
    check_idle(1'b0, "after_b2b");
  endtask

  task automatic test_busy_ignore();
    start_tx(1'b0, 8'h96, 1'b0);
    run_frame(1'b0, 8'h96, 1'b0, 1, 1'b0, 1'b1, "busy_ignore");
    for (int i = 0; i < 8; i++) begin
      check_idle(1'b0, "no_second_frame");
      step();
    end
  endtask

  task automatic test_reset_midframe();
    start_tx(1'b0, 8'h3C, 1'b0);
    set_valid(1'b0, 1'b0);
    repeat (14) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle(1'b0, "abort_reset");
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle(1'b0, "abort_quiet");
    end
    start_tx(1'b0, 8'h3C, 1'b0);
    run_frame(1'b0, 8'h3C, 1'b0, 1, 1'b0, 1'b0, "frame_3c_after_reset");
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    start_tx(1'b0, 8'hA5, 1'b1);
    run_frame(1'b0, 8'hA5, 1'b1, 1, 1'b0, 1'b0, "parity_odd_a5");
    start_tx(1'b0, 8'h07, 1'b0);
    run_frame(1'b0, 8'h07, 1'b0, 1, 1'b0, 1'b0, "parity_even_07");
`else
    start_tx(1'b0, 8'h81, 1'b1);
    run_frame(1'b0, 8'h81, 1'b1, 1, 1'b0, 1'b0, "frame_81");
`endif
  endtask

  task automatic test_stop2();
    start_tx(1'b1, 8'hA5, 1'b0);
    run_frame(1'b1, 8'hA5, 1'b0, 2, 1'b0, 1'b0, "stop2_a5");
    check_idle(1'b1, "after_stop2");
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    in_valid2  = 1'b0;
    parity_odd = 1'b0;
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_reset_midframe();
    test_parity();
    test_stop2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
